seq_divider: RTL
================

# seq_divider

Multi-cycle restoring divider for the RISC-V core datapath, implementing RV32M DIV, DIVU, REM and REMU. It is the subtractive counterpart to the core's adder: it produces one quotient bit per cycle by trial subtraction. It sits beside the ALU, and the control unit stalls the pipeline while `busy` is high.

## Interface
Parameters:
- `WIDTH`, 32, operand and result width in bits.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a division; sampled only in IDLE.
- `op`  in  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU; sampled with `start`.
- `dividend`  in  WIDTH  operand a; sampled with `start`.
- `divisor`  in  WIDTH  operand b; sampled with `start`.
- `busy`  out  1  high while an operation is in progress.
- `done`  out  1  one-cycle pulse when `result` becomes valid.
- `result`  out  WIDTH  quotient (DIV/DIVU) or remainder (REM/REMU); held until the next accepted start.

## Operation
- **States:**
  - IDLE: `busy` = 0. A `start` in IDLE latches `op` and the operands, then moves to CALC.
  - CALC: runs exactly WIDTH cycles, then moves to FIX.
  - FIX: one cycle, then returns to IDLE. `done` pulses in the first IDLE cycle after FIX.
- **Signed ops (DIV/REM):**
  - Operands are converted to magnitudes before CALC.
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder sign = sign(a).
  - Sign correction is applied in FIX.
- **CALC step:**
  - Partial remainder is WIDTH+1 bits.
  - Each cycle: shift left, bring in the next dividend MSB, trial-subtract the divisor magnitude.
  - If the trial result is non-negative, keep it and set the quotient bit to 1. Otherwise restore and set the quotient bit to 0.
- **Divide by zero (b = 0):**
  - Quotient = all ones, for both DIV and DIVU.
  - Remainder = a.
  - No exception is raised.
- **Signed overflow (DIV/REM with a = 1 followed by WIDTH-1 zeros, b = all ones):**
  - Quotient = a.
  - Remainder = 0.
- **Start while busy:** `start` outside IDLE is ignored. Operands and `op` are not re-sampled.
- **Back-to-back operations:** `start` is accepted in the same cycle `done` is high, because that cycle is IDLE.
- **Reset:**
  - `rst` in any state forces IDLE on the next edge and aborts any operation in progress.
  - Reset values: `busy` = 0, `done` = 0, `result` = 0, all internal registers = 0.

## Timing
- Let `start` be accepted in cycle T.
  - `busy` = 1 in cycles T+1 through T+WIDTH+1 (CALC, then FIX).
  - `done` = 1 and `result` is valid in cycle T+WIDTH+2, with `busy` = 0 in that cycle.
- Latency is WIDTH+2 cycles from start to done, i.e. 34 for WIDTH = 32. It is independent of operand values unless the configuration macro below is defined.
- `result` changes only in the cycle `done` rises, or on reset.
- `busy` and `done` are registered outputs with no combinational path from inputs.

## Configuration
- Macro: `SEQ_DIVIDER_FAST_SPECIAL_EN`.
- **Defined:**
  - Divide-by-zero and signed overflow are detected in IDLE when `start` is accepted.
  - The FSM skips CALC and goes directly to FIX.
  - `done` is asserted in cycle T+2 with `busy` = 1 only in T+1.
- **Undefined:**
  - Special cases run the full WIDTH-cycle CALC.
  - The special-case result overrides the datapath in FIX.
  - Latency is always WIDTH+2.
- Results are identical in both builds; only latency differs.

## Test plan
- DIVU 100 / 7, then REMU 100 / 7 -> `result` 14, then 2; `done` in cycle T+34 for each.
- DIV 20 / -3 (0xFFFFFFFD), then REM 20 / -3 -> 0xFFFFFFFA (-6), then 2. REM -20 / 3 -> 0xFFFFFFFE (-2).
- Divide by zero:
  - DIVU 5 / 0 -> 0xFFFFFFFF. REM 5 / 0 -> 5.
  - With `SEQ_DIVIDER_FAST_SPECIAL_EN`, `done` arrives at T+2; otherwise at T+34.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
- Start ignored while busy: `start` with new operands at T+5 -> first result unaffected and no second `done`. A new `start` in the `done` cycle is accepted and `busy` rises next cycle.
- Reset mid-operation: assert `rst` at T+10 for one cycle -> next cycle `busy` = 0, `done` = 0, `result` = 0, and no `done` pulse follows.

Source files
------------

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per CALC cycle. Signed operands are reduced to magnitudes
// on entry; the signs are reapplied in FIX.
// Optional macro SEQ_DIVIDER_FAST_SPECIAL_EN: divide-by-zero and signed
// overflow skip CALC and go straight to FIX. Results are the same either way.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem_r;     // partial remainder, always < divisor magnitude
  logic [WIDTH-1:0] quo_r;     // dividend magnitude shifts out, quotient shifts in
  logic [WIDTH-1:0] bmag_r;
  logic [WIDTH-1:0] a_r;       // original dividend, needed for special results
  logic             neg_q_r;
  logic             neg_r_r;
  logic             is_rem_r;
  logic             div0_r;
  logic             ovf_r;

  // operand conditioning for the cycle start is accepted
  logic             sgn_op;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             is_div0;
  logic             is_ovf;

  assign sgn_op  = ~op[0];
  assign a_neg   = sgn_op & dividend[WIDTH-1];
  assign b_neg   = sgn_op & divisor[WIDTH-1];
  assign a_mag   = a_neg ? -dividend : dividend;
  assign b_mag   = b_neg ? -divisor : divisor;
  assign is_div0 = (divisor == '0);
  assign is_ovf  = sgn_op & (dividend == MIN_INT) & (divisor == '1);

  // one restoring step: shift in next dividend bit, trial-subtract divisor
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;
  assign rem_sh = {rem_r, quo_r[WIDTH-1]};
  assign trial  = rem_sh - {1'b0, bmag_r};

  // sign-corrected results with special-case overrides, used in FIX
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;
  always_comb begin
    quo_fix = neg_q_r ? -quo_r : quo_r;
    rem_fix = neg_r_r ? -rem_r : rem_r;
    if (div0_r) begin
      quo_fix = '1;
      rem_fix = a_r;
    end else if (ovf_r) begin
      quo_fix = a_r;
      rem_fix = '0;
    end
  end

  // control FSM and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      rem_r    <= '0;
      quo_r    <= '0;
      bmag_r   <= '0;
      a_r      <= '0;
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      is_rem_r <= 1'b0;
      div0_r   <= 1'b0;
      ovf_r    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cnt      <= '0;
            rem_r    <= '0;
            quo_r    <= a_mag;
            bmag_r   <= b_mag;
            a_r      <= dividend;
            neg_q_r  <= a_neg ^ b_neg;
            neg_r_r  <= a_neg;
            is_rem_r <= op[1];
            div0_r   <= is_div0;
            ovf_r    <= is_ovf;
            busy     <= 1'b1;
`ifdef SEQ_DIVIDER_FAST_SPECIAL_EN
            state    <= (is_div0 | is_ovf) ? FIX : CALC;
`else
            state    <= CALC;
`endif
          end
        end
        CALC: begin
          // trial[WIDTH] set means the subtraction went negative: restore
          rem_r <= trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
          quo_r <= {quo_r[WIDTH-2:0], ~trial[WIDTH]};
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          result <= is_rem_r ? rem_fix : quo_fix;
          busy   <= 1'b0;
          done   <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
